protocol_in: RTL and testbench

PROTOCOL_IN -- requirements
Module: protocol_in

---
 rtl/protocol_pkg.sv | 12 +
 rtl/protocol_gap_timer.sv | 20 ++
 rtl/protocol_in.sv | 72 +++++++
 tb/tb_protocol_in.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// protocol_pkg: frame byte values, FSM states and error codes shared with the transmit-side encoder
package protocol_pkg;
   localparam logic [7:0] START_BYTE = 8'hFF;
   localparam logic [7:0] SW_ON = 8'd1;
   localparam logic [7:0] SW_OFF = 8'd2;
   localparam logic [7:0] FREQ_MIN = 8'd20;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_SW = 2'd1;
   localparam logic [1:0] ERR_FREQ = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;
   typedef enum logic [1:0] {IDLE, WAIT_SW, WAIT_FREQ} state_t;
endpackage

// File: rtl/protocol_gap_timer.sv
// protocol_gap_timer: counts idle cycles while run is high, flags expiry once the count reaches TIMEOUT_CYCLES
module protocol_gap_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic clk,
   input logic reset,
   input logic run,
   input logic clear,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset || !run || clear) cnt <= '0;
      else if (cnt != LIMIT) cnt <= cnt + W'(1);
   end
   // a byte arriving on the expiry cycle raises clear, which masks the expiry
   assign expired = run && !clear && (cnt == LIMIT);
endmodule

// File: rtl/protocol_in.sv
// protocol_in: decodes FF/switch/frequency UART frames into switcher state, frequency and error pulses
module protocol_in
   import protocol_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic clk,
   input logic reset,
   input logic rx_valid,
   input logic [7:0] rx_data,
   output logic sig_out,
   output logic [7:0] freq_out,
   output logic frame_valid,
   output logic err,
   output logic [1:0] err_code,
   output logic [7:0] frame_count
);
   state_t state;
   logic sw_on;
   logic expired;
   protocol_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
      .clk(clk),
      .reset(reset),
      .run(state != IDLE),
      .clear(rx_valid),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sw_on <= 1'b0;
         sig_out <= 1'b0;
         freq_out <= '0;
         frame_valid <= 1'b0;
         err <= 1'b0;
         err_code <= ERR_NONE;
         frame_count <= '0;
      end else begin
         frame_valid <= 1'b0;
         err <= 1'b0;
         if (rx_valid) begin
            // a start byte always restarts the frame, from any state
            if (rx_data == START_BYTE) state <= WAIT_SW;
            else if (state == WAIT_SW) begin
               if (rx_data == SW_ON || rx_data == SW_OFF) begin
                  sw_on <= (rx_data == SW_ON);
                  state <= WAIT_FREQ;
               end else begin
                  err <= 1'b1;
                  err_code <= ERR_SW;
                  state <= IDLE;
               end
            end else if (state == WAIT_FREQ) begin
               if (rx_data >= FREQ_MIN) begin
                  sig_out <= sw_on;
                  freq_out <= rx_data;
                  frame_count <= frame_count + 8'd1;
                  frame_valid <= 1'b1;
               end else begin
                  err <= 1'b1;
                  err_code <= ERR_FREQ;
               end
               state <= IDLE;
            end
         end else if (expired) begin
            err <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_protocol_in.sv
// tb_protocol_in: directed frame vectors with hand-computed expectations, TIMEOUT_CYCLES=16
module tb_protocol_in;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic sig_out;
   logic [7:0] freq_out;
   logic frame_valid;
   logic err;
   logic [1:0] err_code;
   logic [7:0] frame_count;
   int n_checks = 0;
   int n_fails = 0;
   int fv_n = 0;
   int err_n = 0;
   int both_n = 0;
   protocol_in #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk),
      .reset(reset),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .sig_out(sig_out),
      .freq_out(freq_out),
      .frame_valid(frame_valid),
      .err(err),
      .err_code(err_code),
      .frame_count(frame_count)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (frame_valid) fv_n++;
      if (err) err_n++;
      if (frame_valid && err) both_n++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data = b;
      tick();
      rx_valid = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) tick();
   endtask
   task automatic outs(input string tag, input logic s, input logic [7:0] f, input logic [1:0] c, input logic [7:0] n);
      check({tag, "_sig"}, 32'(sig_out), 32'(s));
      check({tag, "_freq"}, 32'(freq_out), 32'(f));
      check({tag, "_code"}, 32'(err_code), 32'(c));
      check({tag, "_count"}, 32'(frame_count), 32'(n));
   endtask
   initial begin
      idle(2);
      outs("rst", 0, 8'h00, 0, 0);
      check("rst_fv", 32'(frame_valid), 0);
      check("rst_err", 32'(err), 0);
      reset = 1'b0;
      idle(2);
      send(8'hFF); idle(9);
      send(8'h01); idle(9);
      send(8'h64);
      check("t1_fv", 32'(frame_valid), 1);
      outs("t1", 1, 8'h64, 0, 1);
      idle(9);
      check("t1_fv_low", 32'(frame_valid), 0);
      check("t1_fv_total", 32'(fv_n), 1);
      send(8'hFF); send(8'h02); send(8'h14);
      check("t2_fv", 32'(frame_valid), 1);
      outs("t2", 0, 8'h14, 0, 2);
      idle(3);
      send(8'h13);
      check("t2_idle_err", 32'(err), 0);
      idle(3);
      outs("t2_idle", 0, 8'h14, 0, 2);
      check("t2_err_total", 32'(err_n), 0);
      send(8'hFF); send(8'h05);
      check("t3_sw_err", 32'(err), 1);
      outs("t3_sw", 0, 8'h14, 1, 2);
      tick();
      check("t3_sw_pulse", 32'(err), 0);
      send(8'hFF); send(8'h01); send(8'h0A);
      check("t3_fr_err", 32'(err), 1);
      check("t3_fr_fv", 32'(frame_valid), 0);
      outs("t3_fr", 0, 8'h14, 2, 2);
      idle(2);
      send(8'hFF); send(8'h01); send(8'hFF); send(8'h02); send(8'h32);
      check("t4_fv", 32'(frame_valid), 1);
      outs("t4", 0, 8'h32, 2, 3);
      idle(2);
      check("t4_err_total", 32'(err_n), 2);
      check("t4_fv_total", 32'(fv_n), 3);
      send(8'hFF); idle(16);
      check("t5_pre_err", 32'(err), 0);
      tick();
      check("t5_to_err", 32'(err), 1);
      check("t5_to_code", 32'(err_code), 3);
      tick();
      send(8'h01);
      check("t5_idle_after_to", 32'(err), 0);
      idle(2);
      send(8'hFF); idle(16);
      send(8'h01);
      check("t5_edge_sw_err", 32'(err), 0);
      idle(16);
      send(8'h64);
      check("t5_edge_fv", 32'(frame_valid), 1);
      check("t5_edge_err", 32'(err), 0);
      outs("t5_edge", 1, 8'h64, 3, 4);
      idle(2);
      check("t5_err_total", 32'(err_n), 3);
      send(8'hFF); send(8'h01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      outs("t6_rst", 0, 8'h00, 0, 0);
      send(8'h64);
      check("t6_after_fv", 32'(frame_valid), 0);
      check("t6_after_err", 32'(err), 0);
      outs("t6_after", 0, 8'h00, 0, 0);
      send(8'hFF); send(8'h01); send(8'h64);
      check("t6_fv", 32'(frame_valid), 1);
      outs("t6", 1, 8'h64, 0, 1);
      idle(2);
      check("fv_total", 32'(fv_n), 5);
      check("err_total", 32'(err_n), 3);
      check("fv_err_overlap", 32'(both_n), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
